// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES core between two requesters.
// Round-robin pick in IDLE, operand capture at grant, load strobe for LOAD_LEN
// cycles, then track core busy with start/run timeouts and report done/err.
module aes_core_arbiter #(
    parameter int unsigned LOAD_LEN = 4,
    parameter int unsigned START_TO = 16,
    parameter int unsigned RUN_TO   = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic [1:0]     req_i,
    input  logic [127:0]   r0_data_i,
    input  logic [255:0]   r0_key_i,
    input  logic           r0_dec_i,
    input  logic [1:0]     r0_size_i,
    input  logic [127:0]   r1_data_i,
    input  logic [255:0]   r1_key_i,
    input  logic           r1_dec_i,
    input  logic [1:0]     r1_size_i,
    output logic [1:0]     gnt_o,
    output logic [1:0]     done_o,
    output logic [1:0]     err_o,
    output logic [127:0]   result_o,
    output logic           active_o,
    output logic           aes_load_o,
    output logic           aes_dec_o,
    output logic [1:0]     aes_size_o,
    output logic [127:0]   aes_data_o,
    output logic [255:0]   aes_key_o,
    input  logic [127:0]   aes_data_i,
    input  logic           aes_busy_i
);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitBusy, StRun} state_e;

    localparam logic [CNT_W-1:0] LoadLast  = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] StartLast = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] RunLast   = CNT_W'(RUN_TO - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr;      // index of the most recent winner
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [1:0]       r_err;
    logic [127:0]     r_result;
    logic             r_load;
    logic             r_dec;
    logic [1:0]       r_size;
    logic [127:0]     r_data;
    logic [255:0]     r_key;

    logic             w_any;
    logic             w_pick;
    logic [127:0]     w_data;
    logic [255:0]     w_key;
    logic             w_dec;
    logic [1:0]       w_size;

    // Round-robin winner selection and operand mux for the winner.
    always_comb begin
        w_any = |req_i;
        case (req_i)
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_rr;   // contention: the one that did not win last
            default: w_pick = 1'b0;
        endcase
        w_data = w_pick ? r1_data_i : r0_data_i;
        w_key  = w_pick ? r1_key_i  : r0_key_i;
        w_dec  = w_pick ? r1_dec_i  : r0_dec_i;
        w_size = w_pick ? r1_size_i : r0_size_i;
    end

    // Control FSM with registered outputs; done/err are single-cycle pulses.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_rr     <= 1'b1;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_result <= '0;
            r_load   <= 1'b0;
            r_dec    <= 1'b0;
            r_size   <= '0;
            r_data   <= '0;
            r_key    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_data  <= w_data;
                        r_key   <= w_key;
                        r_dec   <= w_dec;
                        r_size  <= w_size;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_rr    <= w_pick;
                        r_load  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    // Busy is ignored here; the core may still see a stale level.
                    if (r_cnt == LoadLast) begin
                        r_load  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StWaitBusy;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitBusy: begin
                    if (aes_busy_i) begin
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end else if (r_cnt == StartLast) begin
                        r_err   <= r_gnt;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (!aes_busy_i) begin
                        r_result <= aes_data_i;
                        r_done   <= r_gnt;
                        r_gnt    <= '0;
                        r_cnt    <= '0;
                        r_state  <= StIdle;
                    end else if (r_cnt == RunLast) begin
                        r_err   <= r_gnt;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign gnt_o      = r_gnt;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign result_o   = r_result;
    assign active_o   = (r_state != StIdle);
    assign aes_load_o = r_load;
    assign aes_dec_o  = r_dec;
    assign aes_size_o = r_size;
    assign aes_data_o = r_data;
    assign aes_key_o  = r_key;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core model, scoreboard of expected
// completions, table of single operations and hand-written corner sequences.
module tb_aes_core_arbiter;

    localparam int LoadLen = 4;
    localparam int StartTo = 16;
    localparam int RunTo   = 1024;

    localparam int ModeNormal = 0;
    localparam int ModeNever  = 1;
    localparam int ModeStuck  = 2;

    localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FipsKey = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_i = '0;
    logic [127:0] r0_data = '0, r1_data = '0;
    logic [255:0] r0_key = '0, r1_key = '0;
    logic         r0_dec = 1'b0, r1_dec = 1'b0;
    logic [1:0]   r0_size = '0, r1_size = '0;
    logic [1:0]   gnt_o, done_o, err_o;
    logic [127:0] result_o;
    logic         active_o, aes_load_o, aes_dec_o;
    logic [1:0]   aes_size_o;
    logic [127:0] aes_data_o;
    logic [255:0] aes_key_o;
    logic [127:0] aes_data_i = '0;
    logic         aes_busy_i = 1'b0;

    aes_core_arbiter #(
        .LOAD_LEN (LoadLen),
        .START_TO (StartTo),
        .RUN_TO   (RunTo),
        .CNT_W    (11)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req_i),
        .r0_data_i  (r0_data),
        .r0_key_i   (r0_key),
        .r0_dec_i   (r0_dec),
        .r0_size_i  (r0_size),
        .r1_data_i  (r1_data),
        .r1_key_i   (r1_key),
        .r1_dec_i   (r1_dec),
        .r1_size_i  (r1_size),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .result_o   (result_o),
        .active_o   (active_o),
        .aes_load_o (aes_load_o),
        .aes_dec_o  (aes_dec_o),
        .aes_size_o (aes_size_o),
        .aes_data_o (aes_data_o),
        .aes_key_o  (aes_key_o),
        .aes_data_i (aes_data_i),
        .aes_busy_i (aes_busy_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stand-in for the AES core: the FIPS-197 vector gives the known ciphertext,
    // anything else gets a cheap operand-dependent scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [255:0] k,
                                             input logic dec, input logic [1:0] sz);
        if (d == FipsPt && k == FipsKey && !dec && sz == 2'd0) return FipsCt;
        return {d[63:0], d[127:64]} ^ k[255:128] ^ k[127:0] ^ {126'd0, sz} ^ {128{dec}};
    endfunction

    // ---------------- core model ----------------
    int           core_mode = ModeNormal;
    int           busy_len  = 12;
    logic         core_kill = 1'b0;
    int           cm_phase  = 0;
    int           cm_cnt    = 0;
    logic [127:0] cm_d;
    logic [255:0] cm_k;
    logic         cm_dec;
    logic [1:0]   cm_sz;

    always @(negedge clk) begin
        if (core_kill) begin
            aes_busy_i = 1'b0;
            cm_phase   = 0;
        end else begin
            case (cm_phase)
                0: if (aes_load_o) begin
                    cm_d = aes_data_o; cm_k = aes_key_o; cm_dec = aes_dec_o; cm_sz = aes_size_o;
                    cm_phase = 1;
                end
                1: if (!aes_load_o) begin
                    if (core_mode == ModeNever) begin
                        cm_phase = 0;
                    end else begin
                        aes_busy_i = 1'b1;
                        cm_cnt     = 0;
                        cm_phase   = 2;
                    end
                end
                default: begin
                    cm_cnt++;
                    if (core_mode == ModeNormal && cm_cnt >= busy_len) begin
                        aes_busy_i = 1'b0;
                        aes_data_i = core_fn(cm_d, cm_k, cm_dec, cm_sz);
                        cm_phase   = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [1:0]   owner;
        logic [1:0]   done;
        logic [1:0]   err;
        logic [127:0] result;
        int           lat;     // grant-to-pulse cycles, 0 = unchecked
    } sb_t;
    sb_t sb[$];

    int         cyc       = 0;
    int         grant_cyc = 0;
    int         load_cnt  = 0;
    logic [1:0] prev_gnt  = '0;
    logic [1:0] cur_gnt   = '0;

    always @(negedge clk) begin
        sb_t e;
        if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
            cur_gnt   = gnt_o;
            grant_cyc = cyc;
        end
        prev_gnt = gnt_o;
        if (aes_load_o) begin
            load_cnt++;
        end else if (load_cnt != 0) begin
            chk("load_len", 256'(load_cnt), 256'(LoadLen));
            load_cnt = 0;
        end
        if ((done_o | err_o) != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual done=%b err=%b required none", done_o, err_o);
            end else begin
                e = sb.pop_front();
                chk("done_o", 256'(done_o), 256'(e.done));
                chk("err_o", 256'(err_o), 256'(e.err));
                chk("result_o", 256'(result_o), 256'(e.result));
                chk("owner", 256'(cur_gnt), 256'(e.owner));
                chk("gnt_clear", 256'(gnt_o), 256'(0));
                if (e.lat != 0) chk("latency", 256'(cyc - grant_cyc), 256'(e.lat));
            end
        end
        cyc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] owner, input bit is_err, input logic [127:0] res,
                        input int lat);
        sb_t e;
        e.owner  = owner;
        e.done   = is_err ? 2'b00 : owner;
        e.err    = is_err ? owner : 2'b00;
        e.result = res;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || active_o) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual pending=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]   req;
        logic [127:0] d0;
        logic [255:0] k0;
        logic         dec0;
        logic [1:0]   sz0;
        logic [127:0] d1;
        logic [255:0] k1;
        logic         dec1;
        logic [1:0]   sz1;
        int           mode;
        int           blen;
        logic [1:0]   owner;
        bit           is_err;
        int           lat;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] req, input logic [127:0] d0,
                                input logic [255:0] k0, input logic dec0, input logic [1:0] sz0,
                                input logic [127:0] d1, input logic [255:0] k1, input logic dec1,
                                input logic [1:0] sz1, input int mode, input int blen,
                                input logic [1:0] owner, input bit is_err, input int lat);
        vec_t v;
        v.req = req; v.d0 = d0; v.k0 = k0; v.dec0 = dec0; v.sz0 = sz0;
        v.d1 = d1; v.k1 = k1; v.dec1 = dec1; v.sz1 = sz1;
        v.mode = mode; v.blen = blen; v.owner = owner; v.is_err = is_err; v.lat = lat;
        return v;
    endfunction

    vec_t         vecs[6];
    logic [127:0] last_res = '0;
    logic [127:0] exp_res;
    logic [127:0] keep_d;

    initial begin
        vecs[0] = mk(2'b01, FipsPt, FipsKey, 1'b0, 2'd0, '0, '0, 1'b0, 2'd0,
                     ModeNormal, 12, 2'b01, 1'b0, 0);
        vecs[1] = mk(2'b10, '0, '0, 1'b0, 2'd0, 128'hdeadbeef_01234567_89abcdef_cafef00d,
                     {2{128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0}}, 1'b1, 2'd2,
                     ModeNormal, 3, 2'b10, 1'b0, 0);
        vecs[2] = mk(2'b01, 128'h1111, 256'h2222, 1'b0, 2'd1, '0, '0, 1'b0, 2'd0,
                     ModeNever, 5, 2'b01, 1'b1, LoadLen + StartTo);
        vecs[3] = mk(2'b10, '0, '0, 1'b0, 2'd0, 128'h5555_aaaa, 256'h77 << 200, 1'b0, 2'd1,
                     ModeNormal, 1, 2'b10, 1'b0, 0);
        vecs[4] = mk(2'b01, 128'h3333, 256'h4444, 1'b1, 2'd0, '0, '0, 1'b0, 2'd0,
                     ModeStuck, 5, 2'b01, 1'b1, LoadLen + 1 + RunTo);
        vecs[5] = mk(2'b10, '0, '0, 1'b0, 2'd0, 128'hfeed_face, 256'hbead, 1'b1, 2'd2,
                     ModeNormal, 7, 2'b10, 1'b0, 0);

        // reset state
        repeat (3) step();
        chk("rst_gnt", 256'(gnt_o), 256'(0));
        chk("rst_active", 256'(active_o), 256'(0));
        chk("rst_load", 256'(aes_load_o), 256'(0));
        chk("rst_result", 256'(result_o), 256'(0));
        chk("rst_key", aes_key_o, 256'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            r0_data = vecs[i].d0; r0_key = vecs[i].k0; r0_dec = vecs[i].dec0; r0_size = vecs[i].sz0;
            r1_data = vecs[i].d1; r1_key = vecs[i].k1; r1_dec = vecs[i].dec1; r1_size = vecs[i].sz1;
            core_mode = vecs[i].mode;
            busy_len  = vecs[i].blen;
            if (vecs[i].is_err) exp_res = last_res;
            else if (vecs[i].owner == 2'b01)
                exp_res = core_fn(vecs[i].d0, vecs[i].k0, vecs[i].dec0, vecs[i].sz0);
            else
                exp_res = core_fn(vecs[i].d1, vecs[i].k1, vecs[i].dec1, vecs[i].sz1);
            push(vecs[i].owner, vecs[i].is_err, exp_res, vecs[i].lat);
            last_res = exp_res;
            req_i = vecs[i].req;
            step();
            chk("grant", 256'(gnt_o), 256'(vecs[i].owner));
            req_i = '0;
            wait_done("table_op");
            if (i == 0) chk("fips_ct", 256'(result_o), 256'(FipsCt));
            if (vecs[i].mode == ModeStuck) begin
                core_kill = 1'b1;
                step();
                core_kill = 1'b0;
                core_mode = ModeNormal;
            end
            step();
        end

        // both requesting for three operations: alternate starting with 0
        r0_data = 128'h0a0b0c0d; r0_key = 256'h1234; r0_dec = 1'b0; r0_size = 2'd1;
        r1_data = 128'h0f0e0d0c; r1_key = 256'h5678; r1_dec = 1'b1; r1_size = 2'd2;
        busy_len = 4;
        push(2'b01, 1'b0, core_fn(r0_data, r0_key, r0_dec, r0_size), 0);
        push(2'b10, 1'b0, core_fn(r1_data, r1_key, r1_dec, r1_size), 0);
        push(2'b01, 1'b0, core_fn(r0_data, r0_key, r0_dec, r0_size), 0);
        last_res = core_fn(r0_data, r0_key, r0_dec, r0_size);
        req_i = 2'b11;
        for (int n = 0; n < 500 && sb.size() != 0; n++) step();
        req_i = '0;
        chk("rr_drained", 256'(sb.size()), 256'(0));
        sb.delete();
        step();
        step();
        chk("rr_no_repeat", 256'(active_o), 256'(0));

        // requester 1 withdraws and changes its data right after grant
        r1_data = 128'h600d_d00d; r1_key = 256'h99; r1_dec = 1'b0; r1_size = 2'd0;
        keep_d  = r1_data;
        busy_len = 6;
        push(2'b10, 1'b0, core_fn(keep_d, r1_key, r1_dec, r1_size), 0);
        last_res = core_fn(keep_d, r1_key, r1_dec, r1_size);
        req_i = 2'b10;
        step();
        step();
        req_i   = '0;
        r1_data = 128'hbad0_bad0;
        wait_done("change_of_mind");
        chk("operand_hold", 256'(aes_data_o), 256'(keep_d));
        step();

        // reset in the middle of RUN aborts silently
        busy_len = 30;
        r1_data  = 128'h7777;
        req_i    = 2'b10;
        step();
        req_i = '0;
        for (int n = 0; n < 50 && !aes_busy_i; n++) step();
        repeat (3) step();
        chk("pre_rst_active", 256'(active_o), 256'(1));
        rst       = 1'b1;
        core_kill = 1'b1;
        step();
        chk("mid_rst_active", 256'(active_o), 256'(0));
        chk("mid_rst_gnt", 256'(gnt_o), 256'(0));
        chk("mid_rst_pulse", 256'({done_o, err_o}), 256'(0));
        chk("mid_rst_result", 256'(result_o), 256'(0));
        chk("mid_rst_data", 256'(aes_data_o), 256'(0));
        chk("mid_rst_load", 256'(aes_load_o), 256'(0));
        rst       = 1'b0;
        core_kill = 1'b0;
        repeat (3) step();

        // normal service after reset
        r1_data  = 128'h1357_9bdf;
        busy_len = 5;
        push(2'b10, 1'b0, core_fn(r1_data, r1_key, r1_dec, r1_size), 0);
        req_i = 2'b10;
        step();
        req_i = '0;
        wait_done("post_reset");
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES core between two requesters (for example, the Wishbone control path and a streaming source).
- Selects a requester round-robin and captures its operands.
- Drives the core's load strobe, tracks the core's busy signal, and returns the result with a done or error pulse.
- Sits between the requesters and the aes_core load/data/key/busy interface. Single clock domain.

Parameters:
LOAD_LEN, 4, cycles aes_load_o is held high (≥1; covers the core-side 2-flop sync)
START_TO, 16, max cycles in WAIT_BUSY before busy must rise
RUN_TO, 1024, max cycles in RUN before busy must fall
CNT_W, 11, counter width; must hold max(LOAD_LEN, START_TO, RUN_TO)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
req_i  in  2  per-requester level request; bit n = requester n
r0_data_i  in  128  requester 0 plaintext/ciphertext
r0_key_i  in  256  requester 0 key
r0_dec_i  in  1  requester 0 decrypt select
r0_size_i  in  2  requester 0 key size code
r1_data_i, r1_key_i, r1_dec_i, r1_size_i  in  128/256/1/2  requester 1 equivalents
gnt_o  out  2  one-hot; owner of the current operation; 0 when idle
done_o  out  2  one-cycle pulse on the owner's bit; result_o valid
err_o  out  2  one-cycle pulse on the owner's bit; timeout
result_o  out  128  last captured core output; held until next capture
active_o  out  1  high in any state except IDLE
aes_load_o  out  1  core load strobe
aes_dec_o, aes_size_o, aes_data_o, aes_key_o  out  1/2/128/256  registered operands to core
aes_data_i  in  128  core result
aes_busy_i  in  1  core busy, already synchronised to wb_clk_i

Behaviour:
- Reset: state IDLE, all outputs 0, RR pointer = 1 (so requester 0 wins first). Reset mid-operation aborts at the next edge: no done or err pulse, and aes_load_o drops.
- States: IDLE → LOAD → WAIT_BUSY → RUN → IDLE. Counter cnt is cleared on every state entry.
- IDLE, any req_i set at edge N:
  - Pick the winner. If only one bit is set, that requester wins. If both are set, the requester other than the RR pointer wins.
  - At edge N, register the winner's operands into aes_*_o, set gnt_o, update the RR pointer to the winner, and enter LOAD.
- LOAD: aes_load_o=1 for exactly LOAD_LEN cycles (N+1 .. N+LOAD_LEN), then WAIT_BUSY. aes_busy_i is ignored in LOAD.
- WAIT_BUSY:
  - aes_busy_i=1 → RUN.
  - Otherwise, once cnt reaches START_TO-1 with busy still low → err_o[owner] pulse and IDLE.
- RUN:
  - aes_busy_i=0 → capture aes_data_i into result_o, pulse done_o[owner] for one cycle, clear gnt_o, go to IDLE. result_o and done_o change on the same edge.
  - cnt reaches RUN_TO-1 with busy still high → err_o[owner] pulse, gnt_o cleared, IDLE. result_o is unchanged.
- After a done or err pulse: gnt_o=0 and active_o=0 for one IDLE cycle. Arbitration samples req_i in that cycle.
  - A requester still holding req_i gets a new operation; it must drop req_i on seeing done to avoid a repeat.
  - Minimum spacing between loads is therefore LOAD_LEN+3 cycles.
- Requester change-of-mind: req_i falling after grant is ignored, and the operation completes. Operands are captured at grant, so requesters may change their inputs afterwards.
- aes_*_o operand outputs hold their values after the operation until the next grant.
- done_o and err_o are never both set, and at most one bit of each is set.

Test Plan:
- Requester 0 only, AES-128, FIPS-197 key 000102..0f, pt 00112233..ff; core model busy for 12 cycles → aes_load_o high for 4 cycles after grant; done_o=01 once; result_o=69c4e0d8..c55a; gnt_o back to 00.
- req_i=11 held for 3 operations → grants in order 01, 10, 01; each result matches its requester's operands.
- Core model never raises busy → err_o[owner] after 4+16 cycles from grant; done_o never asserts; result_o unchanged.
- Core busy stuck high → err_o after RUN_TO cycles in RUN; the next request is still served correctly.
- wb_rst_i for 1 cycle mid-RUN → next cycle: all outputs 0, no done/err pulse; the subsequent req_i=10 is served normally.
- Requester 1 drops req_i and changes r1_data_i 1 cycle after grant → operation completes with the captured operands and done_o=10.
